receptor_tela_serial: RTL and testbench

// - Serial receiver for the rendered-frame stream that the game core sends on its serial output.
// - Used by the display-side board and by the bench as a frame checker.
// - Deserializes 8N1 UART bytes and reassembles one 16-row x 15-column frame.
// - Emits frame rows one at a time, then reports frame OK or frame error.

---
 rtl/receptor_tela_serial_if.sv | 34 +++
 rtl/receptor_tela_serial.sv | 211 +++++++++++++++++++++
 tb/tb_receptor_tela_serial.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/receptor_tela_serial_if.sv
// Serial line in, reassembled frame rows and status out.
// Slave side is the receiver, master side is whoever drives the line.
interface receptor_tela_serial_if;
  logic        entrada_serial;
  logic        linha_valida;
  logic [3:0]  linha_y;
  logic [14:0] linha_x;
  logic        quadro_pronto;
  logic        erro_quadro;
  logic        recebendo;
  logic [3:0]  db_estado;

  modport master (
    output entrada_serial,
    input  linha_valida,
    input  linha_y,
    input  linha_x,
    input  quadro_pronto,
    input  erro_quadro,
    input  recebendo,
    input  db_estado
  );

  modport slave (
    input  entrada_serial,
    output linha_valida,
    output linha_y,
    output linha_x,
    output quadro_pronto,
    output erro_quadro,
    output recebendo,
    output db_estado
  );
endinterface

// File: rtl/receptor_tela_serial.sv
// 8N1 receiver that rebuilds a header/rows/xor-checksum frame
// and hands rows out one per pulse.
module receptor_tela_serial #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          NUM_LINHAS   = 16,
  parameter int          TIMEOUT_BITS = 20,
  parameter logic [7:0]  CABECALHO    = 8'h7E
) (
  input  logic clock,
  input  logic reset,
  receptor_tela_serial_if.slave bus
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW    = $clog2(LIMIT + 1);

  localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MEIO_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FIM_TO   = TW'(LIMIT - 1);
  localparam logic [3:0]    ULTIMA   = 4'(NUM_LINHAS - 1);

  typedef enum logic [1:0] {
    OCIOSO, INICIO, DADOS, PARADA
  } rx_t;

  typedef enum logic [1:0] {
    ESPERA_CAB, BYTE_ALTO, BYTE_BAIXO, CHECKSUM
  } fr_t;

  logic s1, s2, rx_ant;

  rx_t           rx_st, rx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    nbit, nbit_nx;
  logic [7:0]    dado, dado_nx;
  logic          byte_ok, erro_parada;

  fr_t           f_st, f_nx;
  logic [3:0]    row, row_nx;
  logic [7:0]    xacc, xor_nx;
  logic [6:0]    alto, alto_nx;
  logic [TW-1:0] to_cnt, to_nx;
  logic          timeout;

  logic          lv, lv_nx;
  logic [3:0]    ly, ly_nx;
  logic [14:0]   lx, lx_nx;
  logic          qp, qp_nx;
  logic          eq, eq_nx;

  // rx_ant is the previous synchronized sample, used for edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      rx_ant <= 1'b1;
    end else begin
      s1     <= bus.entrada_serial;
      s2     <= s1;
      rx_ant <= s2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_st <= OCIOSO;
      cnt   <= '0;
      nbit  <= '0;
      dado  <= '0;
    end else begin
      rx_st <= rx_nx;
      cnt   <= cnt_nx;
      nbit  <= nbit_nx;
      dado  <= dado_nx;
    end
  end

  always_comb begin
    rx_nx       = rx_st;
    cnt_nx      = cnt + 1'b1;
    nbit_nx     = nbit;
    dado_nx     = dado;
    byte_ok     = 1'b0;
    erro_parada = 1'b0;
    unique case (rx_st)
      OCIOSO: begin
        cnt_nx = '0;
        if (rx_ant && !s2) rx_nx = INICIO;
      end
      INICIO: begin
        if (cnt == MEIO_BIT) begin
          cnt_nx  = '0;
          nbit_nx = '0;
          rx_nx   = s2 ? OCIOSO : DADOS;
        end
      end
      DADOS: begin
        if (cnt == FIM_BIT) begin
          cnt_nx  = '0;
          dado_nx = {s2, dado[7:1]};
          nbit_nx = nbit + 1'b1;
          if (nbit == 3'd7) rx_nx = PARADA;
        end
      end
      PARADA: begin
        if (cnt == FIM_BIT) begin
          cnt_nx      = '0;
          rx_nx       = OCIOSO;
          byte_ok     = s2;
          erro_parada = !s2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_st   <= ESPERA_CAB;
      row    <= '0;
      xacc   <= '0;
      alto   <= '0;
      to_cnt <= '0;
      lv     <= 1'b0;
      ly     <= '0;
      lx     <= '0;
      qp     <= 1'b0;
      eq     <= 1'b0;
    end else begin
      f_st   <= f_nx;
      row    <= row_nx;
      xacc   <= xor_nx;
      alto   <= alto_nx;
      to_cnt <= to_nx;
      lv     <= lv_nx;
      ly     <= ly_nx;
      lx     <= lx_nx;
      qp     <= qp_nx;
      eq     <= eq_nx;
    end
  end

  // a byte arriving on the expiry cycle still counts and restarts the timer
  always_comb begin
    f_nx    = f_st;
    row_nx  = row;
    xor_nx  = xacc;
    alto_nx = alto;
    lv_nx   = 1'b0;
    ly_nx   = ly;
    lx_nx   = lx;
    qp_nx   = 1'b0;
    eq_nx   = 1'b0;
    to_nx   = (f_st == ESPERA_CAB || byte_ok)
            ? '0 : to_cnt + 1'b1;
    timeout = (f_st != ESPERA_CAB) && !byte_ok
            && (to_cnt == FIM_TO);
    unique case (f_st)
      ESPERA_CAB: begin
        if (byte_ok && dado == CABECALHO) begin
          f_nx   = BYTE_ALTO;
          row_nx = '0;
          xor_nx = '0;
        end
      end
      BYTE_ALTO: begin
        if (byte_ok) begin
          alto_nx = dado[6:0];
          xor_nx  = xacc ^ dado;
          f_nx    = BYTE_BAIXO;
        end
      end
      BYTE_BAIXO: begin
        if (byte_ok) begin
          xor_nx = xacc ^ dado;
          lv_nx  = 1'b1;
          ly_nx  = row;
          lx_nx  = {alto, dado};
          if (row == ULTIMA) begin
            f_nx = CHECKSUM;
          end else begin
            row_nx = row + 1'b1;
            f_nx   = BYTE_ALTO;
          end
        end
      end
      CHECKSUM: begin
        if (byte_ok) begin
          qp_nx = (dado == xacc);
          eq_nx = (dado != xacc);
          f_nx  = ESPERA_CAB;
        end
      end
      default: ;
    endcase
    if (f_st != ESPERA_CAB && (erro_parada || timeout)) begin
      f_nx  = ESPERA_CAB;
      eq_nx = 1'b1;
    end
  end

  assign bus.linha_valida  = lv;
  assign bus.linha_y       = ly;
  assign bus.linha_x       = lx;
  assign bus.quadro_pronto = qp;
  assign bus.erro_quadro   = eq;
  assign bus.recebendo     = (f_st != ESPERA_CAB);
  assign bus.db_estado     = {rx_st, f_st};

endmodule

// File: tb/tb_receptor_tela_serial.sv
// Directed frame scenarios against receptor_tela_serial.
// Rows, pulses and state are recorded on the falling edge.
module tb_receptor_tela_serial;
  localparam int CPB = 8;
  localparam int NL  = 16;
  localparam int TOB = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;

  receptor_tela_serial_if bus ();

  receptor_tela_serial #(
    .CLKS_PER_BIT (CPB),
    .NUM_LINHAS   (NL),
    .TIMEOUT_BITS (TOB),
    .CABECALHO    (8'h7E)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0;
  int n_lv, n_qp, n_eq;
  int lv_cyc, eq_cyc, stop_cyc;
  bit saw_dados;
  logic [3:0]  ys[$];
  logic [14:0] xs[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  hi[NL];
  logic [7:0]  lo[NL];

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (bus.linha_valida) begin
        n_lv++;
        ys.push_back(bus.linha_y);
        xs.push_back(bus.linha_x);
        lv_cyc = cyc;
      end
      if (bus.quadro_pronto) n_qp++;
      if (bus.erro_quadro) begin
        if (n_eq == 0) eq_cyc = cyc;
        n_eq++;
      end
      if (bus.db_estado[3:2] == 2'd2) saw_dados = 1'b1;
    end
  end

  task automatic clr();
    n_lv = 0; n_qp = 0; n_eq = 0;
    lv_cyc = 0; eq_cyc = 0;
    saw_dados = 1'b0;
    ys.delete(); xs.delete();
  endtask

  task automatic idle(input int n);
    bus.entrada_serial = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic put_bit(input logic v);
    bus.entrada_serial = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    stop_cyc = cyc;
    put_bit(!bad);
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b0);
    tx_q.delete();
  endtask

  task automatic rows_simple();
    for (int k = 0; k < NL; k++) begin
      hi[k] = 8'h00;
      lo[k] = 8'(k);
    end
  endtask

  task automatic frame_q(input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    tx_q.push_back(8'h7E);
    for (int k = 0; k < NL; k++) begin
      tx_q.push_back(hi[k]);
      tx_q.push_back(lo[k]);
      x = x ^ hi[k] ^ lo[k];
    end
    tx_q.push_back(x ^ flip);
  endtask

  task automatic test_reset();
    bus.entrada_serial = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_chk++;
    if (bus.linha_valida !== 1'b0)
      $display("FAIL rst_lv got %b want 0", bus.linha_valida);
    else n_pass++;
    n_chk++;
    if (bus.linha_y !== 4'd0)
      $display("FAIL rst_ly got %h want 0", bus.linha_y);
    else n_pass++;
    n_chk++;
    if (bus.linha_x !== 15'd0)
      $display("FAIL rst_lx got %h want 0", bus.linha_x);
    else n_pass++;
    n_chk++;
    if (bus.quadro_pronto !== 1'b0 || bus.erro_quadro !== 1'b0)
      $display("FAIL rst_pulses got %b%b want 00",
               bus.quadro_pronto, bus.erro_quadro);
    else n_pass++;
    n_chk++;
    if (bus.recebendo !== 1'b0)
      $display("FAIL rst_rec got %b want 0", bus.recebendo);
    else n_pass++;
    n_chk++;
    if (bus.db_estado !== 4'd0)
      $display("FAIL rst_db got %h want 0", bus.db_estado);
    else n_pass++;
    reset = 1'b1;
    idle(10);
  endtask

  task automatic test_good_frame();
    clr();
    rows_simple();
    frame_q(8'h00);
    send_q();
    idle(20);
    n_chk++;
    if (n_lv !== NL)
      $display("FAIL good_nrows got %0d want %0d", n_lv, NL);
    else n_pass++;
    for (int k = 0; k < NL; k++) begin
      n_chk++;
      if (ys.size() > k && ys[k] === 4'(k)
          && xs[k] === {hi[k][6:0], lo[k]}) n_pass++;
      else if (ys.size() > k)
        $display("FAIL good_row%0d got y=%0d x=%h want y=%0d x=%h",
                 k, ys[k], xs[k], k, {hi[k][6:0], lo[k]});
      else $display("FAIL good_row%0d got none want row", k);
    end
    n_chk++;
    if (n_qp !== 1 || n_eq !== 0)
      $display("FAIL good_status got qp=%0d eq=%0d want 1 0",
               n_qp, n_eq);
    else n_pass++;
    n_chk++;
    if (bus.recebendo !== 1'b0)
      $display("FAIL good_rec got %b want 0", bus.recebendo);
    else n_pass++;
    n_chk++;
    if (bus.linha_x !== 15'd15 || bus.linha_y !== 4'd15)
      $display("FAIL good_hold got %h/%0d want 000f/15",
               bus.linha_x, bus.linha_y);
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    clr();
    rows_simple();
    frame_q(8'h01);
    send_q();
    idle(20);
    n_chk++;
    if (n_lv !== NL)
      $display("FAIL badck_nrows got %0d want %0d", n_lv, NL);
    else n_pass++;
    n_chk++;
    if (n_eq !== 1 || n_qp !== 0)
      $display("FAIL badck_status got qp=%0d eq=%0d want 0 1",
               n_qp, n_eq);
    else n_pass++;
    clr();
    frame_q(8'h00);
    send_q();
    idle(20);
    n_chk++;
    if (n_qp !== 1 || n_eq !== 0 || n_lv !== NL)
      $display("FAIL badck_next got qp=%0d eq=%0d rows=%0d want 1 0 16",
               n_qp, n_eq, n_lv);
    else n_pass++;
  endtask

  task automatic test_stop_error();
    clr();
    rows_simple();
    tx_q.push_back(8'h7E);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h00);
    send_q();
    send_byte(8'h02, 1'b1);
    idle(4);
    n_chk++;
    if (n_eq !== 1)
      $display("FAIL stop_err got eq=%0d want 1", n_eq);
    else n_pass++;
    n_chk++;
    if (eq_cyc - stop_cyc < 5 || eq_cyc - stop_cyc > 9)
      $display("FAIL stop_lat got %0d want 7", eq_cyc - stop_cyc);
    else n_pass++;
    n_chk++;
    if (bus.recebendo !== 1'b0 || bus.db_estado[1:0] !== 2'd0)
      $display("FAIL stop_idle got rec=%b fr=%0d want 0 0",
               bus.recebendo, bus.db_estado[1:0]);
    else n_pass++;
    n_chk++;
    if (n_lv !== 2)
      $display("FAIL stop_rows got %0d want 2", n_lv);
    else n_pass++;
    idle(2 * CPB);
    for (int k = 3; k < NL; k++) begin
      tx_q.push_back(8'h00);
      tx_q.push_back(8'(k));
    end
    tx_q.push_back(8'h00);
    send_q();
    idle(20);
    n_chk++;
    if (n_lv !== 2 || n_eq !== 1 || n_qp !== 0)
      $display("FAIL stop_ignore got rows=%0d eq=%0d qp=%0d want 2 1 0",
               n_lv, n_eq, n_qp);
    else n_pass++;
    clr();
    frame_q(8'h00);
    send_q();
    idle(20);
    n_chk++;
    if (n_qp !== 1 || n_eq !== 0)
      $display("FAIL stop_next got qp=%0d eq=%0d want 1 0",
               n_qp, n_eq);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clr();
    rows_simple();
    tx_q.push_back(8'h7E);
    for (int k = 0; k < 4; k++) begin
      tx_q.push_back(hi[k]);
      tx_q.push_back(lo[k]);
    end
    send_q();
    idle(200);
    n_chk++;
    if (n_lv !== 4 || n_eq !== 1 || n_qp !== 0)
      $display("FAIL to_status got rows=%0d eq=%0d qp=%0d want 4 1 0",
               n_lv, n_eq, n_qp);
    else n_pass++;
    n_chk++;
    if (eq_cyc - lv_cyc !== TOB * CPB)
      $display("FAIL to_boundary got %0d want %0d",
               eq_cyc - lv_cyc, TOB * CPB);
    else n_pass++;
    n_chk++;
    if (bus.recebendo !== 1'b0)
      $display("FAIL to_rec got %b want 0", bus.recebendo);
    else n_pass++;
    clr();
    bus.entrada_serial = 1'b0;
    repeat (3) @(negedge clock);
    idle(100);
    n_chk++;
    if (saw_dados !== 1'b0 || bus.db_estado !== 4'd0)
      $display("FAIL glitch got dados=%b db=%h want 0 0",
               saw_dados, bus.db_estado);
    else n_pass++;
  endtask

  task automatic test_garbage_7e();
    clr();
    rows_simple();
    hi[2] = 8'h7E; lo[2] = 8'h7E;
    lo[5] = 8'h7E;
    hi[7] = 8'hFF; lo[7] = 8'h01;
    tx_q.push_back(8'h55);
    tx_q.push_back(8'hAA);
    frame_q(8'h00);
    send_q();
    idle(20);
    n_chk++;
    if (n_lv !== NL)
      $display("FAIL g7e_nrows got %0d want %0d", n_lv, NL);
    else n_pass++;
    for (int k = 0; k < NL; k++) begin
      n_chk++;
      if (ys.size() > k && ys[k] === 4'(k)
          && xs[k] === {hi[k][6:0], lo[k]}) n_pass++;
      else if (ys.size() > k)
        $display("FAIL g7e_row%0d got y=%0d x=%h want y=%0d x=%h",
                 k, ys[k], xs[k], k, {hi[k][6:0], lo[k]});
      else $display("FAIL g7e_row%0d got none want row", k);
    end
    n_chk++;
    if (n_qp !== 1 || n_eq !== 0)
      $display("FAIL g7e_status got qp=%0d eq=%0d want 1 0",
               n_qp, n_eq);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clr();
    rows_simple();
    tx_q.push_back(8'h7E);
    for (int k = 0; k < 8; k++) begin
      tx_q.push_back(hi[k]);
      tx_q.push_back(lo[k]);
    end
    tx_q.push_back(hi[8]);
    send_q();
    put_bit(1'b0);
    put_bit(1'b0);
    put_bit(1'b0);
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.recebendo !== 1'b0 || bus.db_estado !== 4'd0)
      $display("FAIL mid_state got rec=%b db=%h want 0 0",
               bus.recebendo, bus.db_estado);
    else n_pass++;
    n_chk++;
    if (bus.linha_x !== 15'd0 || bus.linha_y !== 4'd0)
      $display("FAIL mid_row got %h/%0d want 0/0",
               bus.linha_x, bus.linha_y);
    else n_pass++;
    n_chk++;
    if (bus.linha_valida !== 1'b0 || bus.quadro_pronto !== 1'b0
        || bus.erro_quadro !== 1'b0)
      $display("FAIL mid_pulses got %b%b%b want 000",
               bus.linha_valida, bus.quadro_pronto, bus.erro_quadro);
    else n_pass++;
    @(negedge clock);
    idle(5);
    reset = 1'b1;
    clr();
    idle(100);
    n_chk++;
    if (n_lv !== 0 || n_qp !== 0 || n_eq !== 0)
      $display("FAIL mid_quiet got rows=%0d qp=%0d eq=%0d want 0 0 0",
               n_lv, n_qp, n_eq);
    else n_pass++;
    frame_q(8'h00);
    send_q();
    idle(20);
    n_chk++;
    if (n_lv !== NL || n_qp !== 1 || n_eq !== 0)
      $display("FAIL mid_next got rows=%0d qp=%0d eq=%0d want 16 1 0",
               n_lv, n_qp, n_eq);
    else n_pass++;
  endtask

  initial begin
    bus.entrada_serial = 1'b1;
    clr();
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_stop_error();
    test_timeout();
    test_garbage_7e();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
